// File: rtl/boot_load_sequencer.sv
// rtl/boot_load_sequencer.sv - loads program/data images with zero padding, then releases and times the core
module boot_load_sequencer #(
  parameter int ADDR_W         = 20,
  parameter int PAD_WORDS      = 3,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              GO,
  input  logic              ABORT,
  input  logic              SRC_VALID,
  input  logic [31:0]       SRC_DATA,
  input  logic              SRC_LAST,
  output logic              SRC_READY,
  output logic              LOAD_PROGRAM_CTRL,
  output logic [ADDR_W-1:0] LOAD_PROGRAM_ADDR,
  output logic [31:0]       LOAD_PROGRAM_DATA,
  output logic              LOAD_DATA_CTRL,
  output logic [ADDR_W-1:0] LOAD_DATA_ADDR,
  output logic [31:0]       LOAD_DATA_DATA,
  output logic              CORE_RSTn,
  output logic              CORE_EN,
  output logic              CORE_START,
  input  logic              CORE_OK,
  output logic [31:0]       CYCLE_COUNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [1:0]        ERR_CODE
);

  localparam int PAD_W = (PAD_WORDS > 0) ? $clog2(PAD_WORDS + 1) : 1;
  localparam logic [PAD_W-1:0] PAD_INIT = PAD_W'(PAD_WORDS);
  localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, LOAD_PROG, LOAD_DATA, RELEASE, RUN, DONE_S, ERR_S} state_e;

  state_e            state_q, state_d;
  // One extra bit so that address 2^ADDR_W is representable and can be refused.
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [PAD_W-1:0]  pad_q, pad_d;
  logic              seg_end_q, seg_end_d;
  logic              src_ready_q, src_ready_d;
  logic              prog_ctrl_q, prog_ctrl_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [31:0]       prog_data_q, prog_data_d;
  logic              data_ctrl_q, data_ctrl_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [31:0]       data_data_q, data_data_d;
  logic              core_rstn_q, core_rstn_d;
  logic              core_en_q, core_en_d;
  logic              core_start_q, core_start_d;
  logic [31:0]       cnt_q, cnt_d, cnt_inc;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              wr_req, wr_last;
  logic [31:0]       wr_data;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pad_q        <= '0;
      seg_end_q    <= 1'b0;
      src_ready_q  <= 1'b0;
      prog_ctrl_q  <= 1'b0;
      prog_addr_q  <= '0;
      prog_data_q  <= '0;
      data_ctrl_q  <= 1'b0;
      data_addr_q  <= '0;
      data_data_q  <= '0;
      core_rstn_q  <= 1'b0;
      core_en_q    <= 1'b0;
      core_start_q <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pad_q        <= pad_d;
      seg_end_q    <= seg_end_d;
      src_ready_q  <= src_ready_d;
      prog_ctrl_q  <= prog_ctrl_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      data_ctrl_q  <= data_ctrl_d;
      data_addr_q  <= data_addr_d;
      data_data_q  <= data_data_d;
      core_rstn_q  <= core_rstn_d;
      core_en_q    <= core_en_d;
      core_start_q <= core_start_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pad_d       = pad_q;
    seg_end_d   = seg_end_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 32'd1;
    err_code_d  = err_code_q;
    prog_ctrl_d = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    data_ctrl_d = 1'b0;
    data_addr_d = data_addr_q;
    data_data_d = data_data_q;
    wr_req      = 1'b0;
    wr_last     = 1'b0;
    wr_data     = '0;

    case (state_q)
      IDLE, DONE_S, ERR_S: begin
        if (GO) begin
          state_d    = LOAD_PROG;
          addr_d     = '0;
          pad_d      = '0;
          seg_end_d  = 1'b0;
          cnt_d      = '0;
          err_code_d = 2'd0;
        end
      end
      LOAD_PROG, LOAD_DATA: begin
        if (pad_q != '0) begin
          wr_req  = 1'b1;
          pad_d   = pad_q - PAD_W'(1);
          wr_last = (pad_q == PAD_W'(1)) && seg_end_q;
        end else if (SRC_VALID && src_ready_q) begin
          wr_req    = 1'b1;
          wr_data   = SRC_DATA;
          pad_d     = PAD_INIT;
          seg_end_d = SRC_LAST;
          wr_last   = SRC_LAST && (PAD_INIT == '0);
        end
        if (wr_req) begin
          if (addr_q[ADDR_W]) begin
            state_d    = ERR_S;
            err_code_d = 2'd1;
            pad_d      = '0;
            seg_end_d  = 1'b0;
          end else begin
            if (state_q == LOAD_PROG) begin
              prog_ctrl_d = 1'b1;
              prog_addr_d = addr_q[ADDR_W-1:0];
              prog_data_d = wr_data;
            end else begin
              data_ctrl_d = 1'b1;
              data_addr_d = addr_q[ADDR_W-1:0];
              data_data_d = wr_data;
            end
            addr_d = addr_q + (ADDR_W+1)'(1);
            if (wr_last) begin
              addr_d    = '0;
              seg_end_d = 1'b0;
              state_d   = (state_q == LOAD_PROG) ? LOAD_DATA : RELEASE;
            end
          end
        end
      end
      RELEASE: state_d = RUN;
      RUN: begin
        if (CORE_OK) begin
          state_d = DONE_S;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT) begin
            state_d    = ERR_S;
            err_code_d = 2'd2;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every other event on the same edge.
    if (ABORT) begin
      state_d     = IDLE;
      prog_ctrl_d = 1'b0;
      data_ctrl_d = 1'b0;
      addr_d      = '0;
      pad_d       = '0;
      seg_end_d   = 1'b0;
      cnt_d       = cnt_q;
      err_code_d  = 2'd0;
    end

    src_ready_d  = ((state_d == LOAD_PROG) || (state_d == LOAD_DATA)) && (pad_d == '0) && !seg_end_d;
    core_rstn_d  = (state_d == RELEASE) || (state_d == RUN) || (state_d == DONE_S);
    core_en_d    = core_rstn_d;
    core_start_d = (state_d == RUN);
    busy_d       = (state_d == LOAD_PROG) || (state_d == LOAD_DATA) || (state_d == RELEASE) || (state_d == RUN);
    done_d       = (state_d == DONE_S);
    error_d      = (state_d == ERR_S);
  end

  assign SRC_READY         = src_ready_q;
  assign LOAD_PROGRAM_CTRL = prog_ctrl_q;
  assign LOAD_PROGRAM_ADDR = prog_addr_q;
  assign LOAD_PROGRAM_DATA = prog_data_q;
  assign LOAD_DATA_CTRL    = data_ctrl_q;
  assign LOAD_DATA_ADDR    = data_addr_q;
  assign LOAD_DATA_DATA    = data_data_q;
  assign CORE_RSTn         = core_rstn_q;
  assign CORE_EN           = core_en_q;
  assign CORE_START        = core_start_q;
  assign CYCLE_COUNT       = cnt_q;
  assign BUSY              = busy_q;
  assign DONE              = done_q;
  assign ERROR             = error_q;
  assign ERR_CODE          = err_code_q;

endmodule

// File: tb/tb_boot_load_sequencer.sv
// tb/tb_boot_load_sequencer.sv - directed vector bench for boot_load_sequencer
module tb_boot_load_sequencer;

  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic GO = 1'b0;
  logic ABORT = 1'b0;
  logic SRC_VALID = 1'b0;
  logic [31:0] SRC_DATA = '0;
  logic SRC_LAST = 1'b0;
  logic CORE_OK = 1'b0;

  logic a_rdy, a_pc, a_dc, a_crst, a_cen, a_cst, a_busy, a_done, a_err;
  logic [2:0] a_pa, a_da;
  logic [31:0] a_pd, a_dd, a_cnt;
  logic [1:0] a_ec;
  logic t_rdy, t_pc, t_dc, t_crst, t_cen, t_cst, t_busy, t_done, t_err;
  logic [19:0] t_pa, t_da;
  logic [31:0] t_pd, t_dd, t_cnt;
  logic [1:0] t_ec;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  boot_load_sequencer #(.ADDR_W(3), .PAD_WORDS(3), .TIMEOUT_CYCLES(1000000)) dut_a (
    .CLK(CLK), .RSTn(RSTn), .GO(GO), .ABORT(ABORT),
    .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA), .SRC_LAST(SRC_LAST), .SRC_READY(a_rdy),
    .LOAD_PROGRAM_CTRL(a_pc), .LOAD_PROGRAM_ADDR(a_pa), .LOAD_PROGRAM_DATA(a_pd),
    .LOAD_DATA_CTRL(a_dc), .LOAD_DATA_ADDR(a_da), .LOAD_DATA_DATA(a_dd),
    .CORE_RSTn(a_crst), .CORE_EN(a_cen), .CORE_START(a_cst), .CORE_OK(CORE_OK),
    .CYCLE_COUNT(a_cnt), .BUSY(a_busy), .DONE(a_done), .ERROR(a_err), .ERR_CODE(a_ec)
  );

  boot_load_sequencer #(.ADDR_W(20), .PAD_WORDS(3), .TIMEOUT_CYCLES(5)) dut_t (
    .CLK(CLK), .RSTn(RSTn), .GO(GO), .ABORT(ABORT),
    .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA), .SRC_LAST(SRC_LAST), .SRC_READY(t_rdy),
    .LOAD_PROGRAM_CTRL(t_pc), .LOAD_PROGRAM_ADDR(t_pa), .LOAD_PROGRAM_DATA(t_pd),
    .LOAD_DATA_CTRL(t_dc), .LOAD_DATA_ADDR(t_da), .LOAD_DATA_DATA(t_dd),
    .CORE_RSTn(t_crst), .CORE_EN(t_cen), .CORE_START(t_cst), .CORE_OK(CORE_OK),
    .CYCLE_COUNT(t_cnt), .BUSY(t_busy), .DONE(t_done), .ERROR(t_err), .ERR_CODE(t_ec)
  );

  typedef struct {
    logic go, valid, last, ok;
    logic [31:0] data;
    logic rdy, pc;
    logic [2:0] pa;
    logic [31:0] pd;
    logic dc;
    logic [2:0] da;
    logic [31:0] dd;
    logic crst, cen, cst, busy, done;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[24];

  logic [31:0] wq_data[$];
  logic        wq_last[$];
  logic [35:0] exp_q[$];

  function automatic vec_t mk(logic go, logic v, logic [31:0] d, logic l, logic ok,
                              logic rdy, logic pc, logic [2:0] pa, logic [31:0] pd,
                              logic dc, logic [2:0] da, logic [31:0] dd,
                              logic crst, logic cen, logic cst, logic busy, logic done,
                              logic [31:0] cnt);
    vec_t r;
    r.go = go; r.valid = v; r.data = d; r.last = l; r.ok = ok;
    r.rdy = rdy; r.pc = pc; r.pa = pa; r.pd = pd;
    r.dc = dc; r.da = da; r.dd = dd;
    r.crst = crst; r.cen = cen; r.cst = cst; r.busy = busy; r.done = done; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    wq_data.push_back(d);
    wq_last.push_back(l);
  endtask

  // A source word plus its three zero pad writes at consecutive addresses.
  task automatic exp_word(input logic port, input int addr, input logic [31:0] d);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({port, 3'(addr + i), (i == 0) ? d : 32'd0});
  endtask

  task automatic run_stream(input bit rnd, input int budget);
    int cyc;
    logic v;
    logic [35:0] e;
    cyc = 0;
    while (!((wq_data.size() == 0) && (exp_q.size() == 0)) && !a_err && (cyc < budget)) begin
      @(negedge CLK);
      cyc++;
      if (a_pc && a_dc) chk("both_ports_written", 64'd1, 64'd0);
      if (a_pc || a_dc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("write", 64'({a_dc, a_pc ? a_pa : a_da, a_pc ? a_pd : a_dd}), 64'(e));
        end
      end
      if (wq_data.size() != 0) begin
        v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        SRC_VALID = v;
        SRC_DATA  = v ? wq_data[0] : $urandom;
        SRC_LAST  = v ? wq_last[0] : 1'b0;
        if (v && a_rdy) begin
          void'(wq_data.pop_front());
          void'(wq_last.pop_front());
        end
      end else begin
        SRC_VALID = 1'b0;
        SRC_LAST  = 1'b0;
      end
    end
    chk("stream_left", 64'(exp_q.size() + wq_data.size()), 64'd0);
    exp_q.delete();
    wq_data.delete();
    wq_last.delete();
  endtask

  task automatic start();
    @(negedge CLK);
    SRC_VALID = 1'b0; SRC_LAST = 1'b0; CORE_OK = 1'b0;
    ABORT = 1'b1; GO = 1'b1;
    @(negedge CLK);
    chk("abort_beats_go", 64'({a_busy, a_pc, a_dc, a_crst}), 64'd0);
    ABORT = 1'b0; GO = 1'b1;
    @(negedge CLK);
    GO = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(1, 0, 0,  0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[1] = mk(0, 1, WA, 0, 0, 0, 1, 0, WA, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[2] = mk(0, 0, 0,  0, 0, 0, 1, 1, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[3] = mk(0, 0, 0,  0, 0, 0, 1, 2, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[4] = mk(0, 0, 0,  0, 0, 1, 1, 3, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[5] = mk(0, 1, WB, 1, 0, 0, 1, 4, WB, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[6] = mk(0, 0, 0,  0, 0, 0, 1, 5, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[7] = mk(0, 0, 0,  0, 0, 0, 1, 6, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[8] = mk(0, 0, 0,  0, 0, 1, 1, 7, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[9] = mk(0, 1, WC, 1, 0, 0, 0, 7, 0,  1, 0, WC, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 7, 0,  1, 1, 0,  0, 0, 0, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 7, 0,  1, 2, 0,  0, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 7, 0,  1, 3, 0,  1, 1, 0, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 7, 0,  0, 3, 0,  1, 1, 1, 1, 0, 0);
    for (int k = 1; k <= 9; k++)
      tbl[13 + k] = mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 3, 0, 1, 1, 1, 1, 0, 32'(k));
    tbl[23] = mk(0, 0, 0, 0, 1, 0, 0, 7, 0,  0, 3, 0,  1, 1, 0, 0, 1, 9);

    repeat (3) @(negedge CLK);
    chk("reset_ctrl", 64'({a_rdy, a_pc, a_dc, a_crst, a_cen, a_cst}), 64'd0);
    chk("reset_addr_data", 64'({a_pa, a_da, a_pd ^ a_dd}), 64'd0);
    chk("reset_status", 64'({a_busy, a_done, a_err, a_ec, a_cnt}), 64'd0);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_after_reset", 64'({a_busy, a_rdy, a_pc, a_crst}), 64'd0);

    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      GO = tbl[i].go; SRC_VALID = tbl[i].valid; SRC_DATA = tbl[i].data;
      SRC_LAST = tbl[i].last; CORE_OK = tbl[i].ok;
      @(posedge CLK);
      #1;
      chk($sformatf("row%0d_ready", i), 64'(a_rdy), 64'(tbl[i].rdy));
      chk($sformatf("row%0d_prog_ctrl", i), 64'(a_pc), 64'(tbl[i].pc));
      chk($sformatf("row%0d_prog_addr", i), 64'(a_pa), 64'(tbl[i].pa));
      chk($sformatf("row%0d_prog_data", i), 64'(a_pd), 64'(tbl[i].pd));
      chk($sformatf("row%0d_data_ctrl", i), 64'(a_dc), 64'(tbl[i].dc));
      chk($sformatf("row%0d_data_addr", i), 64'(a_da), 64'(tbl[i].da));
      chk($sformatf("row%0d_data_data", i), 64'(a_dd), 64'(tbl[i].dd));
      chk($sformatf("row%0d_core", i), 64'({a_crst, a_cen, a_cst}),
          64'({tbl[i].crst, tbl[i].cen, tbl[i].cst}));
      chk($sformatf("row%0d_status", i), 64'({a_busy, a_done, a_err, a_ec}),
          64'({tbl[i].busy, tbl[i].done, 3'b000}));
      chk($sformatf("row%0d_count", i), 64'(a_cnt), 64'(tbl[i].cnt));
    end
    @(negedge CLK);
    GO = 1'b0; SRC_VALID = 1'b0; CORE_OK = 1'b0;
    chk("done_holds_count", 64'({a_done, a_cnt}), 64'({1'b1, 32'd9}));

    // Same image with random SRC_VALID stalls, including valid during padding.
    start();
    push_word(WA, 1'b0); push_word(WB, 1'b1); push_word(WC, 1'b1);
    exp_word(1'b0, 0, WA); exp_word(1'b0, 4, WB); exp_word(1'b1, 0, WC);
    run_stream(1'b1, 400);
    chk("stall_release", 64'({a_crst, a_cen, a_cst, a_busy}), 64'b1101);
    @(negedge CLK);
    chk("stall_run", 64'({a_crst, a_cen, a_cst}), 64'b111);

    // Third program word would need address 8 on a 3-bit bus.
    start();
    push_word(WA, 1'b0); push_word(WB, 1'b0); push_word(WC, 1'b0);
    exp_word(1'b0, 0, WA); exp_word(1'b0, 4, WB);
    run_stream(1'b0, 200);
    @(negedge CLK);
    SRC_VALID = 1'b0;
    chk("overflow_state", 64'({a_err, a_ec, a_pc, a_busy, a_done}), 64'({1'b1, 2'd1, 3'b000}));

    // Timeout on the TIMEOUT_CYCLES=5 instance with CORE_OK held low.
    start();
    push_word(WA, 1'b1); push_word(WC, 1'b1);
    exp_word(1'b0, 0, WA); exp_word(1'b1, 0, WC);
    run_stream(1'b0, 200);
    for (int n = 0; (n < 40) && !t_err; n++) @(negedge CLK);
    chk("timeout_code", 64'(t_ec), 64'd2);
    chk("timeout_count", 64'(t_cnt), 64'd5);
    chk("timeout_flags", 64'({t_err, t_busy, t_cst, t_done}), 64'b1000);
    @(negedge CLK);
    chk("timeout_count_hold", 64'(t_cnt), 64'd5);

    // Abort (k=0) and reset (k=1) in the middle of the data segment.
    for (int k = 0; k < 2; k++) begin
      start();
      push_word(WA, 1'b0); push_word(WB, 1'b1);
      exp_word(1'b0, 0, WA); exp_word(1'b0, 4, WB);
      run_stream(1'b0, 200);
      SRC_VALID = 1'b1; SRC_DATA = WC; SRC_LAST = 1'b1;
      @(negedge CLK);
      SRC_VALID = 1'b0; SRC_LAST = 1'b0;
      chk("mid_data_write", 64'({a_dc, a_da, a_dd}), 64'({1'b1, 3'd0, WC}));
      @(negedge CLK);
      if (k == 0) begin
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("abort_outputs", 64'({a_pc, a_dc, a_crst, a_cen, a_busy, a_rdy}), 64'd0);
      end else begin
        RSTn = 1'b0;
        #1;
        chk("reset_outputs", 64'({a_pc, a_dc, a_crst, a_cen, a_busy, a_rdy}), 64'd0);
        chk("reset_addr", 64'({a_pa, a_da, a_cnt}), 64'd0);
        chk("reset_data", 64'({a_pd, a_dd}), 64'd0);
        @(negedge CLK);
        RSTn = 1'b1;
      end
      repeat (3) @(negedge CLK);
      chk("stay_idle", 64'({a_busy, a_rdy, a_pc, a_dc, a_crst}), 64'd0);
      start();
      push_word(WA, 1'b0);
      exp_word(1'b0, 0, WA);
      run_stream(1'b0, 100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_load_sequencer.md
BOOT_LOAD_SEQUENCER -- requirements
Module: boot_load_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, meaning the width of the load address buses.
REQ-002 The block SHALL have parameter PAD_WORDS, default 3, meaning the number of zero words written after each source word.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum number of RUN cycles before an error is raised.
REQ-004 CLK  in  1  clock; the block SHALL use a single clock, with all state changing on the rising edge.
REQ-005 RSTn  in  1  reset; the block SHALL use an asynchronous, active-low reset.
REQ-006 GO  in  1  single-cycle pulse that starts a load-and-run sequence; it is honoured in IDLE, DONE or ERROR.
REQ-007 ABORT  in  1  synchronous abort request; it is honoured in every state.
REQ-008 SRC_VALID  in  1  source word valid.
REQ-009 SRC_DATA  in  32  source word.
REQ-010 SRC_LAST  in  1  marks the last word of the current segment (program segment, then data segment).
REQ-011 SRC_READY  out  1  the block accepts a source word on an edge where SRC_VALID and SRC_READY are both 1.
REQ-012 LOAD_PROGRAM_CTRL / LOAD_PROGRAM_ADDR / LOAD_PROGRAM_DATA  out  1 / ADDR_W / 32  instruction-memory write port.
REQ-013 LOAD_DATA_CTRL / LOAD_DATA_ADDR / LOAD_DATA_DATA  out  1 / ADDR_W / 32  data-memory write port.
REQ-014 CORE_RSTn / CORE_EN / CORE_START  out  1 each  datapath reset, enable and start.
REQ-015 CORE_OK  in  1  datapath completion flag.
REQ-016 CYCLE_COUNT  out  32  number of RUN cycles counted.
REQ-017 BUSY / DONE / ERROR  out  1 each  status flags.
REQ-018 ERR_CODE  out  2  error cause: 0 none, 1 address overflow, 2 timeout.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, LOAD_PROG, LOAD_DATA, RELEASE, RUN, DONE_S and ERR_S, and all outputs SHALL be registered.
REQ-020 GO in IDLE, DONE_S or ERR_S SHALL move the FSM to LOAD_PROG and clear the address counter, CYCLE_COUNT, ERR_CODE, DONE and ERROR.
REQ-021 SRC_READY SHALL be 1 only in LOAD_PROG or LOAD_DATA while the pad counter is 0 and no segment-end is pending.
REQ-022 An accepted word SHALL drive, on the next cycle, the active port's CTRL=1, ADDR=address counter and DATA=SRC_DATA, and SHALL then increment the address counter.
REQ-023 After each accepted word, the block SHALL write PAD_WORDS consecutive cycles with CTRL=1, DATA=0 and an incrementing address, with SRC_READY=0 during the padding.
REQ-024 CTRL SHALL be 0 in any cycle with no write, and ADDR/DATA SHALL hold their last value in that cycle.
REQ-025 After the last pad write of a word accepted with SRC_LAST=1, LOAD_PROG SHALL go to LOAD_DATA and LOAD_DATA SHALL go to RELEASE, with the address counter reset to 0.
REQ-026 SRC_VALID=0 stalls SHALL be tolerated at any point without any effect on address or data.
REQ-027 A write required at address 2^ADDR_W SHALL go to ERR_S with ERR_CODE=1, and no write SHALL be issued at that address.
REQ-028 CORE_RSTn SHALL be 0 in every state except RELEASE, RUN and DONE_S.
REQ-029 CORE_EN SHALL be 1 only in RELEASE, RUN and DONE_S.
REQ-030 CORE_START SHALL be 1 only in RUN.
REQ-031 RELEASE SHALL last exactly 1 cycle (CORE_RSTn=1, CORE_EN=1, CORE_START=0) and then go to RUN.
REQ-032 On each edge in RUN with CORE_OK=0, CYCLE_COUNT SHALL increment by 1.
REQ-033 On the edge in RUN with CORE_OK=1, the FSM SHALL go to DONE_S without incrementing CYCLE_COUNT, and DONE SHALL become 1.
REQ-034 If CYCLE_COUNT reaches TIMEOUT_CYCLES in RUN, the FSM SHALL go to ERR_S with ERR_CODE=2; if CORE_OK=1 on that same edge, CORE_OK wins.
REQ-035 CYCLE_COUNT SHALL hold its value in DONE_S and ERR_S.
REQ-036 ABORT SHALL move the FSM to IDLE from any state and clear all CTRL outputs, with CORE_RSTn=0.
REQ-037 ABORT SHALL win over GO, CORE_OK, timeout and overflow when they occur on the same edge.
REQ-038 BUSY SHALL be 1 in LOAD_PROG, LOAD_DATA, RELEASE and RUN.
REQ-039 ERROR SHALL be 1 only in ERR_S, and DONE SHALL be 1 only in DONE_S.

Reset
REQ-040 RSTn=0 SHALL immediately force IDLE, all CTRL=0, all ADDR/DATA=0, SRC_READY=0, CORE_RSTn=0, CORE_EN=0, CORE_START=0, CYCLE_COUNT=0, BUSY=0, DONE=0, ERROR=0 and ERR_CODE=0.
REQ-041 Reset applied mid-load or mid-run SHALL discard all progress, and the block SHALL remain in IDLE after RSTn rises until the next GO.

Verification
REQ-042 Program {A,B(last)}, data {C(last)}, PAD_WORDS=3 -> program writes at 0..7 with data A,0,0,0,B,0,0,0; data writes at 0..3 with data C,0,0,0; then RELEASE for 1 cycle, then RUN.
REQ-043 CORE_OK asserted in the 10th RUN cycle -> CYCLE_COUNT=9, DONE=1, CORE_EN=1, CORE_START=0.
REQ-044 SRC_VALID toggled randomly during load -> write sequence identical to REQ-042, with no duplicate or skipped address.
REQ-045 ADDR_W=3, PAD_WORDS=3, three program words -> writes at 0..7 only, then ERROR=1 and ERR_CODE=1.
REQ-046 TIMEOUT_CYCLES=5 with CORE_OK held 0 -> ERR_CODE=2 and CYCLE_COUNT=5.
REQ-047 ABORT or RSTn=0 in the middle of LOAD_DATA -> IDLE with all CTRL=0 and CORE_RSTn=0; a following GO restarts the load at program address 0.
